// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for an eight-digit seven-segment display.
// Holds an 8-entry frame buffer of {valid, dp, nibble} written by the
// calculator datapath and lights one digit at a time through shared segment
// lines, with a blanking gap between digits to suppress ghosting.
//
// Parameters:
//   DIV    - SHOW cycles per digit (>= 2)
//   BLANK  - dead cycles between digits (>= 1)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   wr_en       in   frame buffer write strobe
//   wr_pos      in   [2:0] digit position for the write
//   wr_data     in   [3:0] hex nibble for the write
//   wr_dp       in   decimal-point flag stored with the digit
//   clear       in   invalidates all eight digits (wins over wr_en)
//   an          out  [7:0] anode enables, active-low, bit i = digit i
//   seg         out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick  out  one-cycle pulse after the scan wraps from digit 7 to 0
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int BLANK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_pos,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       clear,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    // One counter serves both phases, so size it for the longer one.
    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          wrap;

    logic [7:0]    valid;
    logic [7:0]    dp_buf;
    logic [3:0]    nib_buf [8];

    logic          lit;

    // Active-high a..g pattern for a hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // ---------------------------------------------------------------------
    // Frame buffer. Only the valid bits need reset; dp/nibble of an invalid
    // entry are never displayed. clear takes priority and drops a
    // coincident write.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_pos] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            dp_buf[wr_pos]  <= wr_dp;
            nib_buf[wr_pos] <= wr_data;
        end
    end

    // ---------------------------------------------------------------------
    // Scan FSM: SHOW for DIV cycles, GAP for BLANK cycles, then next digit.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            SHOW: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end
            end
            GAP: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                    wrap      = (idx == 3'd7);
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered pin drive: reflects the FSM state and buffer contents of the
    // previous cycle, so a write or clear shows up one edge after it lands.
    // ---------------------------------------------------------------------
    assign lit = (state == SHOW) && valid[idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (lit) begin
                an  <= ~(8'd1 << idx);
                seg <= ~{dp_buf[idx], hex_decode(nib_buf[idx])};
            end else begin
                an  <= 8'hFF;
                seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl with DIV=4, BLANK=2. A reference
// model derives the expected pins from the cycle count since reset release
// and a shadow frame buffer; expectations are queued at each rising edge and
// compared against the DUT on the following falling edge.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int P     = DIV + BLANK;
    localparam int FRAME = 8 * P;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_pos;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       clear;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    display_scan_ctrl #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_pos     (wr_pos),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .clear      (clear),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_cur;

    // Shadow frame buffer and edge count since reset release.
    int         cyc;
    logic [7:0] m_valid;
    logic [7:0] m_dp;
    logic [3:0] m_nib [8];

    // Expected pins after edge k: they show the scan position of the cycle
    // before that edge, i.e. k-1 cycles into the scan.
    function automatic exp_t model_out(input int k);
        exp_t e;
        int   s, d, ph;
        s = k - 1;
        d = (s / P) % 8;
        ph = s % P;
        e.an  = 8'hFF;
        e.seg = 8'hFF;
        if (ph < DIV && m_valid[d]) begin
            e.an  = ~(8'h01 << d);
            e.seg = ~{m_dp[d], HEX[m_nib[d]]};
        end
        e.tick = ((k % FRAME) == 0);
        return e;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc     <= 0;
            m_valid <= '0;
        end else begin
            sb_q.push_back(model_out(cyc + 1));
            cyc <= cyc + 1;
            if (clear) begin
                m_valid <= '0;
            end else if (wr_en) begin
                m_valid[wr_pos] <= 1'b1;
                m_dp[wr_pos]    <= wr_dp;
                m_nib[wr_pos]   <= wr_data;
            end
        end
    end

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            e_cur = sb_q.pop_front();
            check("an", an, e_cur.an);
            check("seg", seg, e_cur.seg);
            check("frame_tick", {7'd0, frame_tick}, {7'd0, e_cur.tick});
        end else if (!reset) begin
            check("rst_an", an, 8'hFF);
            check("rst_seg", seg, 8'hFF);
            check("rst_tick", {7'd0, frame_tick}, 8'd0);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic write(input int pos, input int data, input bit dp, input bit clr);
        wr_en   = 1'b1;
        wr_pos  = 3'(pos);
        wr_data = 4'(data);
        wr_dp   = dp;
        clear   = clr;
        @(negedge clock);
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    // Wait (bounded) until the next edge will sample scan position s.
    task automatic wait_pos(input int s);
        int n;
        n = 0;
        while ((cyc % FRAME) != s && n < 2 * FRAME) begin
            @(negedge clock);
            n++;
        end
        if ((cyc % FRAME) != s) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: position %0d not reached, at %0d", s, cyc % FRAME);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(3);
        sb_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_pos  = '0;
        wr_data = '0;
        wr_dp   = 1'b0;
        clear   = 1'b0;
        @(negedge clock);
        do_reset();

        // Empty buffer: all blank, frame_tick every FRAME cycles.
        idle(2 * FRAME + 2);

        // Single digit at position 3.
        write(3, 4'h7, 1'b0, 1'b0);
        idle(FRAME + 4);

        // Full frame of digits, dp on digit 5.
        for (int i = 0; i < 8; i++) write(i, i, (i == 5), 1'b0);
        idle(FRAME + 8);

        // Rewrite digit 2 while it is being shown.
        write(2, 4'h1, 1'b0, 1'b0);
        wait_pos(13);
        write(2, 4'hE, 1'b0, 1'b0);
        idle(FRAME);

        // Same-cycle clear and write: clear wins, then a plain write.
        write(0, 4'h8, 1'b0, 1'b1);
        idle(FRAME);
        write(0, 4'h8, 1'b0, 1'b0);
        idle(FRAME);

        // Asynchronous reset in the middle of digit 6.
        write(6, 4'hA, 1'b1, 1'b0);
        wait_pos(37);
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        check("async_an", an, 8'hFF);
        check("async_seg", seg, 8'hFF);
        check("async_tick", {7'd0, frame_tick}, 8'd0);
        sb_q.delete();
        idle(3);
        reset = 1'b1;

        // Buffer erased: stays blank until a new write.
        idle(FRAME);
        write(0, 4'h0, 1'b0, 1'b0);
        idle(FRAME + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
